lcd_watch_disp_ctrl: RTL and testbench
======================================

# lcd_watch_disp_ctrl

Display refresh sequencer for the LCD watch. On each update request it snapshots the hour, minute and second values and time-shares one two-digit separator across the three fields. It converts each tens/units digit pair to ASCII and writes the characters one at a time to the LCD character writer over a request/acknowledge handshake. It sits between the watch counters and the LCD driver and owns the only separator instance.

## Interface
- BASE_ADDR, default 7'h00: LCD DDRAM address of the first (hour-tens) character.
- CLK  in  1  system clock; all state updates on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- UPDATE  in  1  one-cycle refresh request (e.g. 1 Hz tick or a set-mode edit).
- HOUR  in  7  hour value, 0..99 legal.
- MIN  in  7  minute value, 0..99 legal.
- SEC  in  7  second value, 0..99 legal.
- SEP_NUM  out  7  value presented to the shared separator.
- SEP_A  in  4  tens digit returned by the separator (combinational).
- SEP_B  in  4  units digit returned by the separator (combinational).
- LCD_REQ  out  1  character write request.
- LCD_ADDR  out  7  character address; stable while LCD_REQ=1.
- LCD_DATA  out  8  ASCII character; stable while LCD_REQ=1.
- LCD_ACK  in  1  writer accepted the character.
- BUSY  out  1  high from the first cycle after an accepted UPDATE through FIN.
- DONE  out  1  one-cycle pulse when the last character is acknowledged.

## Operation
- States: IDLE, LOAD, WR_T, WR_U, WR_C, FIN. Field index FI: 0=hour, 1=min, 2=sec.
- IDLE + UPDATE=1: snapshot HOUR/MIN/SEC into registers, FI=0, go to LOAD. Later input changes do not affect the frame in progress.
- LOAD: SEP_NUM = snapshot[FI]. Register SEP_A and SEP_B at the end of the cycle, then go to WR_T.
- WR_T writes ASCII 8'h30+tens, then goes to WR_U. WR_U writes 8'h30+units.
- After WR_U: if FI<2, go to WR_C (colon macro enabled) or to LOAD (macro disabled) with FI+1. If FI=2, go to FIN.
- WR_C writes 8'h3A, then FI+1 and LOAD.
- FIN: DONE=1 for one cycle, then IDLE.
- Address: character position p counts 0.. in write order. LCD_ADDR = BASE_ADDR + p with 7-bit wrap, so 7'h7F+1 gives 7'h00.
- Values above 99 come back from the separator as 0/0 and are written as "00". No error is flagged.
- UPDATE while BUSY sets a one-deep PENDING flag; further UPDATEs are absorbed. On leaving FIN with PENDING=1, the block takes a fresh snapshot, clears PENDING and goes straight to LOAD, skipping IDLE. DONE still pulses for the finished frame.
- LCD_ACK is ignored while LCD_REQ=0.
- SEP_NUM = 0 outside LOAD.

## Timing
- Reset (asynchronous, any state) forces:
  - state IDLE, PENDING=0, FI=0, p=0
  - LCD_REQ=0, LCD_ADDR=BASE_ADDR, LCD_DATA=8'h20
  - SEP_NUM=0, BUSY=0, DONE=0
- Reset mid-frame abandons the frame. No DONE is produced and no further REQ is issued.
- UPDATE sampled at edge k: LOAD during cycle k+1, BUSY=1 from k+1.
- LCD_REQ rises registered in the first cycle of each WR_* state and holds with stable ADDR/DATA until LCD_ACK=1 is sampled. It is low in the following cycle (minimum one idle cycle between characters).
- With LCD_ACK tied high, per field: LOAD 1 cycle + 2 cycles per character.
  - Colon enabled: 3+16+1 = 20 cycles UPDATE→IDLE.
  - Colon disabled: 3+12+1 = 16 cycles.
- DONE is asserted in FIN, the cycle after the final ACK. BUSY falls with the return to IDLE.

## Configuration
- LCD_WATCH_COLON_EN defined:
  - 8-character frame "HH:MM:SS", p=0..7.
  - Colons written at p=2 and p=5.
- Not defined:
  - 6-character frame "HHMMSS", p=0..5.
  - WR_C is unreachable and omitted.

## Test plan
- Reset, then UPDATE with HOUR=12, MIN=34, SEC=56, ACK tied high, colon enabled: writes 31,32,3A,33,34,3A,35,36 at addr 00..07. DONE pulses at cycle 20.
- Same stimulus, colon disabled: writes 31,32,33,34,35,36 at addr 00..05. DONE at cycle 16.
- ACK delayed 3 cycles per character: REQ/ADDR/DATA held stable for 4 cycles each, then REQ low one cycle. No character is lost or duplicated.
- HOUR=7, MIN=100, SEC=99, BASE_ADDR=7'h7E: writes "07:00:99" with addresses 7E,7F,00,01,…; values above 99 render as "00".
- Two UPDATEs during a frame, with HOUR changed to 23 between them: exactly one extra frame, started directly after FIN, showing 23. Two DONE pulses in total.
- RESETN low during WR_U of the minute field: all outputs at reset values immediately. No DONE. A subsequent UPDATE produces a complete frame from p=0.

Source files
------------

// File: rtl/lcd_watch_disp_ctrl.sv
// Display refresh sequencer: snapshots hour/min/sec, time-shares one separator and writes ASCII digits to the LCD.
// Optional colon characters between fields are built when LCD_WATCH_COLON_EN is defined.
module lcd_watch_disp_ctrl #(
  parameter logic [6:0] BASE_ADDR = 7'h00
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       UPDATE,
  input  logic [6:0] HOUR,
  input  logic [6:0] MIN,
  input  logic [6:0] SEC,
  output logic [6:0] SEP_NUM,
  input  logic [3:0] SEP_A,
  input  logic [3:0] SEP_B,
  output logic       LCD_REQ,
  output logic [6:0] LCD_ADDR,
  output logic [7:0] LCD_DATA,
  input  logic       LCD_ACK,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] DBG_STATE
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WR_T = 3'd2,
    WR_U = 3'd3,
`ifdef LCD_WATCH_COLON_EN
    WR_C = 3'd4,
`endif
    FIN  = 3'd5
  } state_t;

  state_t     state, state_n;
  logic       pend, pend_n;
  logic [1:0] fi, fi_n;
  logic [2:0] p, p_n;
  logic [6:0] snap_h, snap_m, snap_s;
  logic [6:0] snap_h_n, snap_m_n, snap_s_n;
  logic [3:0] units_q, units_n;
  logic       req_n;
  logic [6:0] addr_n;
  logic [7:0] data_n;
  logic       take_snap;

  // Handshake: LCD_REQ with LCD_ADDR/LCD_DATA is a valid signal; LCD_ACK is its ready.
  // A character transfers on a rising edge where both are high; REQ and its payload stay
  // frozen until then, REQ drops for at least one cycle after each transfer, and ACK is
  // ignored whenever REQ is low.

  assign BUSY      = (state != IDLE);
  assign DONE      = (state == FIN);
  assign DBG_STATE = state;

  always_comb begin
    state_n   = state;
    pend_n    = pend;
    fi_n      = fi;
    p_n       = p;
    snap_h_n  = snap_h;
    snap_m_n  = snap_m;
    snap_s_n  = snap_s;
    units_n   = units_q;
    req_n     = LCD_REQ;
    addr_n    = LCD_ADDR;
    data_n    = LCD_DATA;
    SEP_NUM   = 7'd0;
    take_snap = 1'b0;

    if (state != IDLE && UPDATE) pend_n = 1'b1;

    case (state)
      IDLE: begin
        if (UPDATE) take_snap = 1'b1;
      end
      LOAD: begin
        case (fi)
          2'd0:    SEP_NUM = snap_h;
          2'd1:    SEP_NUM = snap_m;
          default: SEP_NUM = snap_s;
        endcase
        // The tens digit is captured straight into the outgoing character; only units wait.
        units_n = SEP_B;
        state_n = WR_T;
        req_n   = 1'b1;
        addr_n  = BASE_ADDR + {4'b0, p};
        data_n  = 8'h30 + {4'h0, SEP_A};
      end
      WR_T: begin
        if (LCD_REQ) begin
          if (LCD_ACK) begin
            req_n = 1'b0;
            p_n   = p + 3'd1;
          end
        end else begin
          state_n = WR_U;
          req_n   = 1'b1;
          addr_n  = BASE_ADDR + {4'b0, p};
          data_n  = 8'h30 + {4'h0, units_q};
        end
      end
      WR_U: begin
        if (LCD_REQ) begin
          if (LCD_ACK) begin
            req_n = 1'b0;
            p_n   = p + 3'd1;
          end
        end else if (fi == 2'd2) begin
          state_n = FIN;
        end else begin
`ifdef LCD_WATCH_COLON_EN
          state_n = WR_C;
          req_n   = 1'b1;
          addr_n  = BASE_ADDR + {4'b0, p};
          data_n  = 8'h3A;
`else
          fi_n    = fi + 2'd1;
          state_n = LOAD;
`endif
        end
      end
`ifdef LCD_WATCH_COLON_EN
      WR_C: begin
        if (LCD_REQ) begin
          if (LCD_ACK) begin
            req_n = 1'b0;
            p_n   = p + 3'd1;
          end
        end else begin
          fi_n    = fi + 2'd1;
          state_n = LOAD;
        end
      end
`endif
      FIN: begin
        // A request seen during the frame (or in this last cycle) chains a new frame.
        if (pend || UPDATE) take_snap = 1'b1;
        else                state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (take_snap) begin
      snap_h_n = HOUR;
      snap_m_n = MIN;
      snap_s_n = SEC;
      fi_n     = 2'd0;
      p_n      = 3'd0;
      pend_n   = 1'b0;
      state_n  = LOAD;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      pend     <= 1'b0;
      fi       <= 2'd0;
      p        <= 3'd0;
      snap_h   <= 7'd0;
      snap_m   <= 7'd0;
      snap_s   <= 7'd0;
      units_q  <= 4'd0;
      LCD_REQ  <= 1'b0;
      LCD_ADDR <= BASE_ADDR;
      LCD_DATA <= 8'h20;
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      fi       <= fi_n;
      p        <= p_n;
      snap_h   <= snap_h_n;
      snap_m   <= snap_m_n;
      snap_s   <= snap_s_n;
      units_q  <= units_n;
      LCD_REQ  <= req_n;
      LCD_ADDR <= addr_n;
      LCD_DATA <= data_n;
    end
  end

endmodule

// File: tb/tb_lcd_watch_disp_ctrl.sv
// Directed bench for lcd_watch_disp_ctrl: separator model, ACK responder, character scoreboard.
// Builds for either frame format depending on LCD_WATCH_COLON_EN.
module tb_lcd_watch_disp_ctrl;

  localparam logic [6:0] TB_BASE = 7'h7E;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WR_U = 3'd3;

`ifdef LCD_WATCH_COLON_EN
  localparam int FRAME_CYC = 20;
  localparam int DLY_CYC   = 44;
  string f_a = "12:34:56";
  string f_b = "07:00:99";
  string f_c = "23:34:56";
  string f_d = "12:34";
  string f_e = "09:59:00";
`else
  localparam int FRAME_CYC = 16;
  localparam int DLY_CYC   = 34;
  string f_a = "123456";
  string f_b = "070099";
  string f_c = "233456";
  string f_d = "1234";
  string f_e = "095900";
`endif

  logic       CLK, RESETN, UPDATE;
  logic [6:0] HOUR, MIN, SEC;
  logic [6:0] SEP_NUM;
  logic [3:0] SEP_A, SEP_B;
  logic       LCD_REQ;
  logic [6:0] LCD_ADDR;
  logic [7:0] LCD_DATA;
  logic       LCD_ACK;
  logic       BUSY, DONE;
  logic [2:0] DBG_STATE;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_at = 0;
  logic ack_tied = 1'b1;
  int ack_delay = 0;
  logic [14:0] exp_q[$];

  lcd_watch_disp_ctrl #(.BASE_ADDR(TB_BASE)) dut (
    .CLK(CLK), .RESETN(RESETN), .UPDATE(UPDATE),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC),
    .SEP_NUM(SEP_NUM), .SEP_A(SEP_A), .SEP_B(SEP_B),
    .LCD_REQ(LCD_REQ), .LCD_ADDR(LCD_ADDR), .LCD_DATA(LCD_DATA), .LCD_ACK(LCD_ACK),
    .BUSY(BUSY), .DONE(DONE), .DBG_STATE(DBG_STATE)
  );

  // clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // separator model: two decimal digits, out-of-range renders as 0/0
  always_comb begin
    SEP_A = 4'd0;
    SEP_B = 4'd0;
    if (SEP_NUM <= 7'd99) begin
      SEP_A = 4'(SEP_NUM / 7'd10);
      SEP_B = 4'(SEP_NUM % 7'd10);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [6:0] a;
      a = TB_BASE + 7'(i);
      exp_q.push_back({a, 8'(s[i])});
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
  endtask

  task automatic pulse_update();
    @(posedge CLK); #1 UPDATE = 1'b1;
    @(posedge CLK); #1 UPDATE = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK); #1;
      if (!BUSY) break;
    end
    chk("idle_reached", 32'(BUSY), 32'(0));
  endtask

  // ACK responder: tied high, or raised after ack_delay cycles of REQ
  initial begin
    int rc;
    logic pr;
    LCD_ACK = 1'b0;
    rc = 0;
    pr = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (LCD_REQ) rc = pr ? rc + 1 : 0;
      else         rc = 0;
      pr = LCD_REQ;
      LCD_ACK = ack_tied ? 1'b1 : (LCD_REQ && rc >= ack_delay);
    end
  end

  // monitor / scoreboard
  logic        prev_req = 1'b0;
  logic        prev_acc = 1'b0;
  logic [6:0]  hold_addr = 7'd0;
  logic [7:0]  hold_data = 8'd0;
  int          run = 0;

  always @(negedge CLK) begin
    logic        acc;
    logic [14:0] e;
    if (prev_acc) chk("req_gap", 32'(LCD_REQ), 32'(0));
    if (LCD_REQ && prev_req) begin
      chk("addr_hold", 32'(LCD_ADDR), 32'(hold_addr));
      chk("data_hold", 32'(LCD_DATA), 32'(hold_data));
    end
    run = LCD_REQ ? (prev_req ? run + 1 : 1) : 0;
    acc = LCD_REQ && LCD_ACK;
    if (acc) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7FFF;
      chk("char", 32'({LCD_ADDR, LCD_DATA}), 32'(e));
      chk("req_len", 32'(run), ack_tied ? 32'(1) : 32'(ack_delay + 1));
    end
    if (BUSY) busy_cnt++;
    if (DONE) begin
      done_cnt++;
      done_at = busy_cnt;
    end
    hold_addr = LCD_ADDR;
    hold_data = LCD_DATA;
    prev_req  = LCD_REQ;
    prev_acc  = acc;
  end

  initial begin
    int n;
    RESETN = 1'b0; UPDATE = 1'b0;
    HOUR = 7'd0; MIN = 7'd0; SEC = 7'd0;

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", 32'(LCD_REQ), 32'(0));
    chk("rst_addr", 32'(LCD_ADDR), 32'(TB_BASE));
    chk("rst_data", 32'(LCD_DATA), 32'h20);
    chk("rst_sep", 32'(SEP_NUM), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_done", 32'(DONE), 32'(0));
    chk("rst_state", 32'(DBG_STATE), 32'(S_IDLE));
    RESETN = 1'b1;
    repeat (2) @(posedge CLK);

    // basic frame, ACK tied high
    HOUR = 7'd12; MIN = 7'd34; SEC = 7'd56;
    clear_stats();
    push_str(f_a);
    pulse_update();
    @(negedge CLK); #1;
    chk("load_busy", 32'(BUSY), 32'(1));
    chk("load_state", 32'(DBG_STATE), 32'(S_LOAD));
    chk("load_sep", 32'(SEP_NUM), 32'd12);
    wait_idle();
    chk("f1_busy_cyc", 32'(busy_cnt), 32'(FRAME_CYC));
    chk("f1_done_at", 32'(done_at), 32'(FRAME_CYC));
    chk("f1_done_cnt", 32'(done_cnt), 32'(1));
    chk("f1_q_empty", 32'(exp_q.size()), 32'(0));
    chk("idle_sep", 32'(SEP_NUM), 32'(0));

    // ACK delayed 3 cycles per character
    ack_tied = 1'b0; ack_delay = 3;
    clear_stats();
    push_str(f_a);
    pulse_update();
    wait_idle();
    chk("f2_busy_cyc", 32'(busy_cnt), 32'(DLY_CYC));
    chk("f2_done_cnt", 32'(done_cnt), 32'(1));
    chk("f2_q_empty", 32'(exp_q.size()), 32'(0));
    ack_tied = 1'b1; ack_delay = 0;

    // out-of-range minute, address wrap at 7'h7F
    HOUR = 7'd7; MIN = 7'd100; SEC = 7'd99;
    clear_stats();
    push_str(f_b);
    pulse_update();
    @(negedge CLK); #1;
    chk("f3_load_sep", 32'(SEP_NUM), 32'd7);
    wait_idle();
    chk("f3_done_cnt", 32'(done_cnt), 32'(1));
    chk("f3_q_empty", 32'(exp_q.size()), 32'(0));

    // two UPDATEs mid-frame collapse into one chained frame
    HOUR = 7'd12; MIN = 7'd34; SEC = 7'd56;
    clear_stats();
    push_str(f_a);
    push_str(f_c);
    pulse_update();
    repeat (3) @(posedge CLK);
    pulse_update();
    HOUR = 7'd23;
    pulse_update();
    wait_idle();
    chk("f4_busy_cyc", 32'(busy_cnt), 32'(2 * FRAME_CYC));
    chk("f4_done_at", 32'(done_at), 32'(2 * FRAME_CYC));
    chk("f4_done_cnt", 32'(done_cnt), 32'(2));
    chk("f4_q_empty", 32'(exp_q.size()), 32'(0));

    // reset during the minute units write
    HOUR = 7'd12; MIN = 7'd34; SEC = 7'd56;
    clear_stats();
    push_str(f_d);
    pulse_update();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK); #1;
      if (DBG_STATE == S_WR_U && LCD_REQ) n++;
      if (n == 2) break;
    end
    RESETN = 1'b0;
    #1;
    chk("mid_rst_req", 32'(LCD_REQ), 32'(0));
    chk("mid_rst_addr", 32'(LCD_ADDR), 32'(TB_BASE));
    chk("mid_rst_data", 32'(LCD_DATA), 32'h20);
    chk("mid_rst_sep", 32'(SEP_NUM), 32'(0));
    chk("mid_rst_busy", 32'(BUSY), 32'(0));
    chk("mid_rst_state", 32'(DBG_STATE), 32'(S_IDLE));
    chk("mid_rst_q", 32'(exp_q.size()), 32'(0));
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_rst_done", 32'(done_cnt), 32'(0));
    RESETN = 1'b1;
    repeat (2) @(posedge CLK);

    // full frame after the abandoned one
    HOUR = 7'd9; MIN = 7'd59; SEC = 7'd0;
    clear_stats();
    push_str(f_e);
    pulse_update();
    wait_idle();
    chk("f5_busy_cyc", 32'(busy_cnt), 32'(FRAME_CYC));
    chk("f5_done_cnt", 32'(done_cnt), 32'(1));
    chk("f5_q_empty", 32'(exp_q.size()), 32'(0));

    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
